// File: rtl/uart_tx_serializer_pkg.sv
// UART global types and config helpers shared by the transmit path.
// Optional build macro: UART_TX_PARITY_ERROR_INJECTION_EN.
package UartGlobalPkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [31:0] {
    BAUD_4800  = 32'd4800,
    BAUD_9600  = 32'd9600,
    BAUD_19200 = 32'd19200
  } baudRateEnum;

  typedef enum logic [4:0] {
    OS_13 = 5'd13,
    OS_16 = 5'd16
  } overSamplingEnum;

  typedef enum logic [3:0] {
    DATA_5 = 4'd5,
    DATA_6 = 4'd6,
    DATA_7 = 4'd7,
    DATA_8 = 4'd8
  } dataTypeEnum;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parityTypeEnum;

  typedef enum logic [1:0] {
    STOP_1 = 2'd1,
    STOP_2 = 2'd2
  } stopBitEnum;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uartTxStateEnum;

  localparam baudRateEnum DEFAULT_BAUD = BAUD_9600;

  function automatic logic [31:0] fix_baud(
    input logic [31:0] baud
  );
    return (baud == 32'd0) ? DEFAULT_BAUD : baud;
  endfunction

  function automatic logic [4:0] fix_os(
    input logic [4:0] os
  );
    return (os == OS_13) ? OS_13 : OS_16;
  endfunction

  function automatic logic [3:0] fix_bits(
    input logic [3:0] dt
  );
    return (dt >= 4'd5 && dt <= 4'd8) ? dt : 4'd8;
  endfunction

  function automatic logic fix_stop2(
    input logic [1:0] sb
  );
    return sb[1];
  endfunction

  // Truncating divide; a zero quotient still needs one clock per tick.
  function automatic logic [31:0] calc_divisor(
    input logic [31:0] clk_hz,
    input logic [31:0] baud,
    input logic [4:0]  os
  );
    logic [31:0] prod;
    logic [31:0] div;
    prod = baud * {27'd0, os};
    div  = (prod == 32'd0) ? 32'd0 : clk_hz / prod;
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Oversampling tick generator: sample pulse every divisor clocks,
// bit pulse on the last sample of a bit; held at zero while cleared.
module uart_baud_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] divisor,
  input  logic [4:0]  oversampling,
  output logic        sampleTick,
  output logic        bitTick
);

  logic [31:0] tick_cnt;
  logic [4:0]  sample_cnt;
  logic        tick_wrap;
  logic        sample_wrap;

  assign tick_wrap   = (tick_cnt == divisor - 32'd1);
  assign sample_wrap = (sample_cnt == oversampling - 5'd1);
  assign sampleTick  = !clear && tick_wrap;
  assign bitTick     = sampleTick && sample_wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt   <= 32'd0;
      sample_cnt <= 5'd0;
    end else if (clear) begin
      tick_cnt   <= 32'd0;
      sample_cnt <= 5'd0;
    end else if (tick_wrap) begin
      tick_cnt   <= 32'd0;
      sample_cnt <= sample_wrap ? 5'd0 : sample_cnt + 5'd1;
    end else begin
      tick_cnt   <= tick_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: valid/ready word in, framed serial line out.
// UART_TX_PARITY_ERROR_INJECTION_EN adds cfgParityErrorInjection.
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int          DATA_WIDTH  = UartGlobalPkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           cfgBaudRate,
  input  logic [4:0]            cfgOverSampling,
  input  logic [3:0]            cfgDataType,
  input  logic                  cfgParityEnable,
  input  logic                  cfgParityType,
  input  logic [1:0]            cfgStopBits,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  output logic                  txSerial,
  output logic                  txBusy
`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
  ,
  input  logic                  cfgParityErrorInjection
`endif
);

  import UartGlobalPkg::*;

  uartTxStateEnum state;
  uartTxStateEnum state_d;

  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [31:0] div_q;
  logic [4:0]  os_q;
  logic [3:0]  nbits_q;
  logic        par_en_q;
  logic        par_odd_q;
  logic        stop2_q;
  logic        inj_q;
  logic [3:0]  idx;
  logic        stop_cnt;
  logic        ready_q;
  logic        accept;
  logic        sample_tick;
  logic        bit_tick;
  logic        bit_end;
  logic        last_bit;
  logic        sent_xor;
  logic        par_bit;
  logic        data_bit;
  logic [31:0] baud_fix;
  logic [4:0]  os_fix;

  assign accept   = (state == IDLE) && ready_q && txValid;
  assign baud_fix = fix_baud(cfgBaudRate);
  assign os_fix   = fix_os(cfgOverSampling);
  assign txReady  = ready_q;
  assign txBusy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q    <= '0;
      div_q     <= 32'd1;
      os_q      <= 5'd16;
      nbits_q   <= 4'd8;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else if (accept) begin
      data_q    <= txData;
      div_q     <= calc_divisor(32'(CLK_FREQ_HZ), baud_fix, os_fix);
      os_q      <= os_fix;
      nbits_q   <= fix_bits(cfgDataType);
      par_en_q  <= cfgParityEnable;
      par_odd_q <= cfgParityType;
      stop2_q   <= fix_stop2(cfgStopBits);
    end
  end

`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      inj_q <= 1'b0;
    else if (accept)
      inj_q <= cfgParityErrorInjection;
  end
`else
  assign inj_q = 1'b0;
`endif

  uart_baud_tick_gen u_tick (
    .clk          (clk),
    .reset        (reset),
    .clear        (state == IDLE),
    .divisor      (div_q),
    .oversampling (os_q),
    .sampleTick   (sample_tick),
    .bitTick      (bit_tick)
  );

  assign bit_end  = sample_tick && bit_tick;
  assign last_bit = (idx == nbits_q - 4'd1);
  assign data_sh  = data_q >> idx;
  assign data_bit = data_sh[0];
  assign par_bit  = sent_xor ^ par_odd_q ^ inj_q;

  always_comb begin
    sent_xor = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < int'(nbits_q))
        sent_xor = sent_xor ^ data_q[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (accept) state_d = START;
      START:  if (bit_end) state_d = DATA;
      DATA:   if (bit_end && last_bit)
                state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end && (!stop2_q || stop_cnt))
                state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= 4'd0;
      stop_cnt <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      if (state != DATA)
        idx <= 4'd0;
      else if (bit_end)
        idx <= idx + 4'd1;
      if (state != STOP)
        stop_cnt <= 1'b0;
      else if (bit_end)
        stop_cnt <= 1'b1;
      ready_q <= (state_d == IDLE);
    end
  end

  always_comb begin
    txSerial = 1'b1;
    unique case (1'b1)
      state == START:  txSerial = 1'b0;
      state == DATA:   txSerial = data_bit;
      state == PARITY: txSerial = par_bit;
      default:         txSerial = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame table plus handshake,
// mid-frame config and reset sequences.
module tb_uart_tx_serializer;

  localparam int unsigned CLK_HZ = 1_536_000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cfgBaudRate = 32'd9600;
  logic [4:0]  cfgOverSampling = 5'd16;
  logic [3:0]  cfgDataType = 4'd8;
  logic        cfgParityEnable = 1'b0;
  logic        cfgParityType = 1'b0;
  logic [1:0]  cfgStopBits = 2'd1;
  logic [7:0]  txData = 8'h00;
  logic        txValid = 1'b0;
  logic        txReady;
  logic        txSerial;
  logic        txBusy;
`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
  logic        cfgParityErrorInjection = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_tx_serializer #(
    .CLK_FREQ_HZ (CLK_HZ),
    .DATA_WIDTH  (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfgBaudRate     (cfgBaudRate),
    .cfgOverSampling (cfgOverSampling),
    .cfgDataType     (cfgDataType),
    .cfgParityEnable (cfgParityEnable),
    .cfgParityType   (cfgParityType),
    .cfgStopBits     (cfgStopBits),
    .txData          (txData),
    .txValid         (txValid),
    .txReady         (txReady),
    .txSerial        (txSerial),
    .txBusy          (txBusy)
`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
    ,
    .cfgParityErrorInjection (cfgParityErrorInjection)
`endif
  );

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic [31:0] baud;
    logic [4:0]  os;
    logic [3:0]  dtype;
    logic        pen;
    logic        ptype;
    logic [1:0]  stop;
    logic        inj;
    int          period;
    string       seq;
  } vec_t;

  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input string name, input logic [7:0] data,
    input logic [31:0] baud, input logic [4:0] os,
    input logic [3:0] dtype, input logic pen,
    input logic ptype, input logic [1:0] stop,
    input logic inj, input int period, input string seq
  );
    vec_t v;
    v.name = name; v.data = data; v.baud = baud;
    v.os = os; v.dtype = dtype; v.pen = pen;
    v.ptype = ptype; v.stop = stop; v.inj = inj;
    v.period = period; v.seq = seq;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name,
                         input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %s, required %s", name, got, exp);
    end
  endtask

  task automatic apply_cfg(input vec_t v);
    cfgBaudRate     = v.baud;
    cfgOverSampling = v.os;
    cfgDataType     = v.dtype;
    cfgParityEnable = v.pen;
    cfgParityType   = v.ptype;
    cfgStopBits     = v.stop;
    txData          = v.data;
`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
    cfgParityErrorInjection = v.inj;
`endif
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!txReady && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!txReady)
      chk({name, " ready_timeout"}, txReady, 1);
  endtask

  task automatic run_frame(input vec_t v, input int chg_at,
                           input logic [31:0] chg_baud);
    logic cap[$];
    string got;
    int k, mid, glitch, rdy_bad;
    logic exp_bit;
    wait_ready(v.name);
    apply_cfg(v);
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    k = 0;
    rdy_bad = 0;
    while (txBusy && k < 8000) begin
      cap.push_back(txSerial);
      if (txReady) rdy_bad++;
      k++;
      if (k == chg_at) cfgBaudRate = chg_baud;
      @(negedge clk);
    end
    chk({v.name, " start"}, (k > 0) ? cap[0] : 1'bx, 0);
    got = "";
    glitch = 0;
    for (int b = 0; b < v.seq.len(); b++) begin
      mid = b * v.period + v.period / 2;
      exp_bit = (v.seq.getc(b) == 8'h31);
      if (mid < k)
        got = {got, (cap[mid] === 1'b1) ? "1" :
                    (cap[mid] === 1'b0) ? "0" : "x"};
      else
        got = {got, "-"};
      for (int j = b * v.period; j < (b + 1) * v.period && j < k; j++)
        if (cap[j] !== exp_bit) glitch++;
    end
    chk_str({v.name, " bits"}, got, v.seq);
    chk({v.name, " busy_len"}, k, v.seq.len() * v.period);
    chk({v.name, " shape"}, glitch, 0);
    chk({v.name, " ready_in_frame"}, rdy_bad, 0);
  endtask

  initial begin
    vec_t v;
    int cyc, a1, a2, idle, viol;
    logic smp;

    vecs[0] = mk("a5_even", 8'hA5, 32'd9600, 5'd16, 4'd8,
                 1'b1, 1'b0, 2'd1, 1'b0, 160, "01010010101");
    vecs[1] = mk("ff_5b_odd_2s", 8'hFF, 32'd9600, 5'd16, 4'd5,
                 1'b1, 1'b1, 2'd2, 1'b0, 160, "011111011");
    vecs[2] = mk("3c_7b_19200", 8'h3C, 32'd19200, 5'd16, 4'd7,
                 1'b0, 1'b0, 2'd1, 1'b0, 80, "000111101");
    vecs[3] = mk("sanitize", 8'h81, 32'd0, 5'd7, 4'd12,
                 1'b0, 1'b0, 2'd0, 1'b0, 160, "0100000011");
    vecs[4] = mk("os13_6b_st3", 8'h0F, 32'd9600, 5'd13, 4'd6,
                 1'b1, 1'b0, 2'd3, 1'b0, 156, "0111100011");
    vecs[5] = mk("00_4800_odd", 8'h00, 32'd4800, 5'd16, 4'd5,
                 1'b1, 1'b1, 2'd1, 1'b0, 320, "00000011");
    vecs[6] = mk("div_clamp", 8'h55, 32'd1000000, 5'd16, 4'd8,
                 1'b0, 1'b0, 2'd1, 1'b0, 16, "0101010101");
`ifdef UART_TX_PARITY_ERROR_INJECTION_EN
    vecs[7] = mk("a5_inject", 8'hA5, 32'd9600, 5'd16, 4'd8,
                 1'b1, 1'b0, 2'd1, 1'b1, 160, "01010010111");
`else
    vecs[7] = mk("a5_inject", 8'hA5, 32'd9600, 5'd16, 4'd8,
                 1'b1, 1'b0, 2'd1, 1'b1, 160, "01010010101");
`endif

    #1;
    chk("rst serial", txSerial, 1);
    chk("rst ready", txReady, 0);
    chk("rst busy", txBusy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rel ready_before_edge", txReady, 0);
    @(negedge clk);
    chk("rst_rel ready_after_edge", txReady, 1);

    foreach (vecs[i])
      run_frame(vecs[i], -1, 32'd0);

    // Baud switched to 19200 while the frame is in its data bits.
    run_frame(vecs[0], 600, 32'd19200);
    v = vecs[0];
    v.name = "a5_next_19200";
    v.baud = 32'd19200;
    v.period = 80;
    run_frame(v, -1, 32'd0);

    wait_ready("b2b");
    v = mk("b2b", 8'h01, 32'd9600, 5'd16, 4'd8,
           1'b0, 1'b0, 2'd1, 1'b0, 160, "");
    apply_cfg(v);
    txValid = 1'b1;
    cyc = 0; a1 = -1; a2 = -1; idle = -1; viol = 0;
    while (cyc < 5000 && !(a2 >= 0 && cyc == a2 + 241)) begin
      if (txBusy && txReady) viol++;
      if (txValid && txReady && !txBusy) begin
        if (a1 < 0) a1 = cyc;
        else if (a2 < 0) a2 = cyc;
      end
      if (a1 >= 0 && cyc == a1 + 1) txData = 8'h02;
      if (a1 >= 0 && cyc > a1 && !txBusy && idle < 0) idle = cyc;
      @(negedge clk);
      cyc++;
    end
    smp = txSerial;
    txValid = 1'b0;
    chk("b2b accept_gap", a2 - a1, 1601);
    chk("b2b accept_at_first_idle", a2, idle);
    chk("b2b ready_while_busy", viol, 0);
    chk("b2b second_word_bit0", smp, 0);

    wait_ready("rst_mid");
    apply_cfg(vecs[0]);
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    repeat (720) @(negedge clk);
    chk("rst_mid line_bit3", txSerial, 0);
    chk("rst_mid busy_before", txBusy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid serial", txSerial, 1);
    chk("rst_mid ready", txReady, 0);
    chk("rst_mid busy", txBusy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid ready_after", txReady, 1);
    v = vecs[0];
    v.name = "a5_after_reset";
    run_frame(v, -1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage. It consumes one data word per valid/ready handshake and serializes it onto the UART line using the run-time configuration defined in UartGlobalPkg (baud rate, oversampling, data width, parity, stop bits). It contains its own oversampling tick generator, and its serial output feeds the UART line directly.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency used for the baud divisor computation
DATA_WIDTH, UartGlobalPkg::DATA_WIDTH (8), width of the txData port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cfgBaudRate  input  32  baudRateEnum value (4800/9600/19200)
cfgOverSampling  input  5  overSamplingEnum value (16 or 13)
cfgDataType  input  4  dataTypeEnum value (5..8 data bits)
cfgParityEnable  input  1  1 = append parity bit
cfgParityType  input  1  parityTypeEnum value (0 = EVEN, 1 = ODD)
cfgStopBits  input  2  stopBitEnum value (1 or 2)
txData  input  DATA_WIDTH  word to send, LSB first
txValid  input  1  txData valid
txReady  output  1  block can accept a word
txSerial  output  1  UART line, idle high
txBusy  output  1  frame in progress

Behaviour:
- Reset (async assert, sync deassert handled upstream): txSerial=1, txReady=0, txBusy=0, state=IDLE, all counters=0. txReady rises in the first clock after reset deasserts.
- Handshake: a word is accepted on a rising edge where txValid&&txReady. txReady=1 only in IDLE. txValid while busy is ignored; the word is not captured.
- On accept, latch txData and all cfg* inputs into frame registers. Cfg changes mid-frame have no effect until the next accept.
- Divisor = CLK_FREQ_HZ / (baud*oversampling), integer truncation, 32-bit unsigned arithmetic, forced to 1 if the result is 0.
- Bit period = oversampling*divisor clocks. A tick counter counts 0..divisor-1; a sample counter counts 0..oversampling-1. A bit ends when both counters wrap.
- Config sanitising at latch time:
  - cfgDataType outside 5..8 -> 8.
  - cfgStopBits 0 -> 1; 3 -> 2.
  - cfgOverSampling other than 13 -> 16.
  - Any cfgBaudRate value is used as given; 0 is treated as 9600.
- FSM states: IDLE -> START -> DATA -> PARITY (only when parity is enabled) -> STOP -> IDLE.
  - START: txSerial=0 starting the cycle after accept (1-cycle latency), for one bit period.
  - DATA: bit index i = 0..N-1 drives latched data[i]; bits above N-1 are never sent.
  - PARITY: even = XOR of the N sent bits; odd = inverted XOR.
  - STOP: txSerial=1 for 1 or 2 bit periods.
  - After STOP -> IDLE. txReady=1 in the next cycle, so there is at least 1 idle clock between frames.
- txBusy=1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Reset mid-frame: line returns to 1 immediately (async) and the frame is aborted. No partial resume.

Optional Feature:
UART_TX_PARITY_ERROR_INJECTION_EN
- Defined: adds input port cfgParityErrorInjection (1 bit), latched at accept. When it is 1 and parity is enabled, the transmitted parity bit is inverted.
- Undefined: the port does not exist and parity is always correct.

Decomposition:
- UartGlobalPkg: existing enums (baudRateEnum, overSamplingEnum, dataTypeEnum, parityTypeEnum, stopBitEnum) and DATA_WIDTH.
- Add to the package:
  - typedef enum for FSM states, uartTxStateEnum {IDLE, START, DATA, PARITY, STOP}.
  - Constant DEFAULT_BAUD = BAUD_9600.
- One sub-module, uart_baud_tick_gen: takes the divisor and oversampling, produces a sampleTick pulse and a bitTick pulse. It is cleared on frame start.

Test Plan:
1. CLK_FREQ_HZ=1_536_000, 9600 baud, OS16, 8 bits, even parity, 1 stop, txData=0xA5 -> txSerial sequence 0,1,0,1,0,0,1,0,1,0,1. Each bit lasts 160 clocks; start edge 1 clock after accept; txBusy high for 1760 clocks.
2. Same clock, 5 bits, odd parity, 2 stop, txData=0xFF -> 0,1,1,1,1,1,0(parity),1,1. Upper 3 bits are not sent.
3. Back-to-back: txValid held high with words 0x01 then 0x02 -> second accept occurs exactly 1 idle clock after the first frame's stop ends. txReady=0 throughout each frame.
4. Config change mid-frame (baud 9600->19200 during DATA) -> current frame keeps 160-clock bits; next frame uses 80-clock bits.
5. reset asserted in DATA bit 3 -> txSerial=1, txReady=0, txBusy=0 asynchronously. After release, the next word transmits cleanly from START.
6. With UART_TX_PARITY_ERROR_INJECTION_EN and inject=1, 0xA5 even parity -> parity bit=1; with inject=0 -> parity bit=0.
